// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci run controller: register map, bit
// positions, FSM states and clock-select helpers.
package fib_pkg;

  localparam int          NUM_CLKSEL = 6;
  localparam logic [2:0]  CLKSEL_MAX = 3'(NUM_CLKSEL - 1);
  localparam logic [31:0] WIN_BYTES  = 32'h20;

  localparam logic [4:0] OFF_CTRL   = 5'h00;
  localparam logic [4:0] OFF_STEPS  = 5'h04;
  localparam logic [4:0] OFF_STATUS = 5'h08;
  localparam logic [4:0] OFF_RESULT = 5'h0C;
  localparam logic [4:0] OFF_COUNT  = 5'h10;

  localparam int CTRL_START      = 0;
  localparam int CTRL_ABORT      = 1;
  localparam int CTRL_CLKSEL_LSB = 2;
  localparam int CTRL_IRQ_EN     = 8;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_ABORTED = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  function automatic logic [2:0] clksel_clamp(input logic [2:0] sel);
    return (sel > CLKSEL_MAX) ? CLKSEL_MAX : sel;
  endfunction

  function automatic logic [NUM_CLKSEL-1:0] clksel_onehot(input logic [2:0] sel);
    return NUM_CLKSEL'(1) << sel;
  endfunction

endpackage

// File: rtl/fib_run_ctrl_if.sv
// Wishbone slave bundle for the Fibonacci run controller.
interface fib_run_ctrl_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/fib_wb_regs.sv
// Wishbone register file: decode, single-cycle ack, byte-lane writes,
// START/ABORT pulses and the sticky W1C status bits.
module fib_wb_regs
  import fib_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          VAL_WIDTH  = 30,
  parameter int          STEP_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  fib_run_ctrl_if.slave         wb,
  input  logic                  busy,
  input  logic [STEP_WIDTH-1:0] count,
  input  logic [VAL_WIDTH-1:0]  result,
  input  logic                  done_set,
  input  logic                  ovf_set,
  input  logic                  abrt_set,
  input  logic                  status_clr,
  output logic                  start_pulse,
  output logic                  abort_pulse,
  output logic [2:0]            clksel,
  output logic                  irq_en,
  output logic [STEP_WIDTH-1:0] steps,
  output logic                  done
);

  logic [31:0] off;
  logic [4:0]  word;
  logic        req, acc, wr;
  logic        wr_ctrl, wr_steps, wr_status;
  logic        ovf, aborted;
  logic [31:0] rdata;

  assign off  = wb.wbs_adr_i - BASE_ADDR;
  assign word = {off[4:2], 2'b00};
  assign req  = wb.wbs_stb_i & wb.wbs_cyc_i & (off < WIN_BYTES);
  // Only the first cycle of a request is accepted; the ack cycle blocks a repeat.
  assign acc  = req & ~wb.wbs_ack_o;
  assign wr   = acc & wb.wbs_we_i;

  assign wr_ctrl   = wr && (word == OFF_CTRL);
  assign wr_steps  = wr && (word == OFF_STEPS);
  assign wr_status = wr && (word == OFF_STATUS) && wb.wbs_sel_i[0];

  always_comb begin
    rdata = '0;
    case (word)
      OFF_CTRL: begin
        rdata[CTRL_CLKSEL_LSB +: 3] = clksel;
        rdata[CTRL_IRQ_EN]          = irq_en;
      end
      OFF_STEPS:  rdata[STEP_WIDTH-1:0] = steps;
      OFF_STATUS: begin
        rdata[ST_BUSY]    = busy;
        rdata[ST_DONE]    = done;
        rdata[ST_OVF]     = ovf;
        rdata[ST_ABORTED] = aborted;
      end
      OFF_RESULT: rdata[VAL_WIDTH-1:0]  = result;
      OFF_COUNT:  rdata[STEP_WIDTH-1:0] = count;
      default:    rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb.wbs_ack_o <= 1'b0;
      wb.wbs_dat_o <= '0;
      start_pulse  <= 1'b0;
      abort_pulse  <= 1'b0;
      clksel       <= '0;
      irq_en       <= 1'b0;
      steps        <= '0;
      done         <= 1'b0;
      ovf          <= 1'b0;
      aborted      <= 1'b0;
    end else begin
      wb.wbs_ack_o <= acc;
      wb.wbs_dat_o <= (acc && !wb.wbs_we_i) ? rdata : '0;
      start_pulse  <= wr_ctrl & wb.wbs_sel_i[0] & wb.wbs_dat_i[CTRL_START];
      abort_pulse  <= wr_ctrl & wb.wbs_sel_i[0] & wb.wbs_dat_i[CTRL_ABORT];
      if (wr_ctrl && wb.wbs_sel_i[0])
        clksel <= clksel_clamp(wb.wbs_dat_i[CTRL_CLKSEL_LSB +: 3]);
      if (wr_ctrl && wb.wbs_sel_i[1])
        irq_en <= wb.wbs_dat_i[CTRL_IRQ_EN];
      if (wr_steps) begin
        for (int i = 0; i < STEP_WIDTH; i++)
          if (wb.wbs_sel_i[i/8]) steps[i] <= wb.wbs_dat_i[i];
      end
      // A hardware set in the same cycle as a software clear keeps the bit set.
      done    <= done_set | (done & ~(status_clr | (wr_status & wb.wbs_dat_i[ST_DONE])));
      ovf     <= ovf_set  | (ovf  & ~(status_clr | (wr_status & wb.wbs_dat_i[ST_OVF])));
      aborted <= abrt_set | (aborted & ~(status_clr | (wr_status & wb.wbs_dat_i[ST_ABORTED])));
    end
  end

endmodule

// File: rtl/fib_run_ctrl.sv
// Run controller for the Fibonacci datapath: enables the generator for a
// programmed number of steps, stops early on wrap-around, captures the result.
module fib_run_ctrl
  import fib_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          VAL_WIDTH  = 30,
  parameter int          STEP_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  fib_run_ctrl_if.slave         wb,
  input  logic                  tick,
  input  logic [VAL_WIDTH-1:0]  value,
  output logic                  on,
  output logic [NUM_CLKSEL-1:0] clock_op,
  output logic                  irq
);

  state_e                state, state_nxt;
  logic                  start_pulse, abort_pulse, irq_en, done;
  logic [2:0]            clksel;
  logic [STEP_WIDTH-1:0] steps, count, count_nxt;
  logic [VAL_WIDTH-1:0]  result, prev_p1;
  logic                  tick_p1;
  logic                  run_entry, done_set, ovf_set, abrt_set, capture_now;
  logic                  term, ovf_hit;

  fib_wb_regs #(
    .BASE_ADDR (BASE_ADDR),
    .VAL_WIDTH (VAL_WIDTH),
    .STEP_WIDTH(STEP_WIDTH)
  ) u_regs (
    .clk        (clk),
    .reset      (reset),
    .wb         (wb),
    .busy       (state != IDLE),
    .count      (count),
    .result     (result),
    .done_set   (done_set),
    .ovf_set    (ovf_set),
    .abrt_set   (abrt_set),
    .status_clr (run_entry),
    .start_pulse(start_pulse),
    .abort_pulse(abort_pulse),
    .clksel     (clksel),
    .irq_en     (irq_en),
    .steps      (steps),
    .done       (done)
  );

  assign count_nxt = count + 1'b1;
  assign term      = tick && (count_nxt == steps);
  // The generator value settles one cycle after its tick, so compare then.
  assign ovf_hit   = tick_p1 && (value < prev_p1);
  assign on        = (state == RUN);
  assign irq       = done & irq_en;

  always_comb begin
    state_nxt   = state;
    run_entry   = 1'b0;
    done_set    = 1'b0;
    ovf_set     = 1'b0;
    abrt_set    = 1'b0;
    capture_now = 1'b0;
    case (state)
      IDLE: begin
        if (start_pulse) begin
          if (steps != '0) begin
            state_nxt = RUN;
            run_entry = 1'b1;
          end else begin
            done_set    = 1'b1;
            capture_now = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort_pulse) begin
          state_nxt = IDLE;
          abrt_set  = 1'b1;
        end else begin
          ovf_set = ovf_hit;
          if (ovf_hit || term) state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        done_set    = 1'b1;
        capture_now = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // p1: tick delayed to line up with the settled generator value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_p1  <= 1'b0;
      prev_p1  <= '0;
      count    <= '0;
      result   <= '0;
      clock_op <= '0;
    end else begin
      tick_p1 <= tick;
      if (run_entry || (state == RUN && tick_p1)) prev_p1 <= value;
      if (run_entry)
        count <= '0;
      else if (state == RUN && tick && count != '1)
        count <= count_nxt;
      if (capture_now) result <= value;
      if (run_entry) clock_op <= clksel_onehot(clksel);
    end
  end

endmodule

// File: tb/tb_fib_run_ctrl.sv
// Directed bench for fib_run_ctrl: bus reads are checked by a scoreboard
// monitor, pin-level behaviour is checked inline against hand-computed values.
module tb_fib_run_ctrl;

  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h00;
  localparam logic [31:0] A_STEP = BASE + 32'h04;
  localparam logic [31:0] A_STAT = BASE + 32'h08;
  localparam logic [31:0] A_RES  = BASE + 32'h0C;
  localparam logic [31:0] A_CNT  = BASE + 32'h10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic        gen_rst = 1'b1;
  logic [29:0] gen_a, gen_b;
  logic        on, irq;
  logic [5:0]  clock_op;

  fib_run_ctrl_if wb();

  fib_run_ctrl #(
    .BASE_ADDR (BASE),
    .VAL_WIDTH (30),
    .STEP_WIDTH(16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wb      (wb),
    .tick    (tick),
    .value   (gen_a),
    .on      (on),
    .clock_op(clock_op),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  // Generator model: steps only while enabled, 30-bit wrap.
  always @(posedge clk) begin
    if (gen_rst) begin
      gen_a <= 30'd0;
      gen_b <= 30'd1;
    end else if (tick && on) begin
      gen_a <= gen_b;
      gen_b <= gen_a + gen_b;
    end
  end

  typedef struct {
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic req_we   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  always @(posedge clk) req_we = wb.wbs_we_i;

  always @(negedge clk) begin
    if (wb.wbs_ack_o === 1'b1 && !req_we) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_read_ack: got data 0x%08h, expected no read", wb.wbs_dat_o);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check(e.name, wb.wbs_dat_o, e.exp);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic acked);
    wb.wbs_stb_i = 1'b1;
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_we_i  = we;
    wb.wbs_sel_i = sel;
    wb.wbs_adr_i = adr;
    wb.wbs_dat_i = dat;
    acked = 1'b0;
    for (int i = 0; i < 8 && !acked; i++) begin
      @(posedge clk);
      #1;
      if (wb.wbs_ack_o === 1'b1) acked = 1'b1;
    end
    wb.wbs_stb_i = 1'b0;
    wb.wbs_cyc_i = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic acked;
    wb_xfer(1'b1, adr, dat, sel, acked);
    if (!acked) begin
      n_checks++;
      $display("FAIL write_ack adr=0x%08h: got no ack, expected ack", adr);
    end
  endtask

  task automatic wb_read(input logic [31:0] adr, input logic [31:0] exp, input string name);
    logic acked;
    sb_q.push_back('{exp, name});
    wb_xfer(1'b0, adr, 32'h0, 4'hF, acked);
    if (!acked) begin
      void'(sb_q.pop_back());
      n_checks++;
      $display("FAIL %s: got no ack, expected 0x%08h", name, exp);
    end
  endtask

  task automatic tick_pulse();
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic gen_reset();
    gen_rst = 1'b1;
    @(posedge clk);
    #1;
    gen_rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acked;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_sel_i = 4'h0;
    wb.wbs_adr_i = 32'h0;
    wb.wbs_dat_i = 32'h0;
    cycles(3);
    reset   = 1'b0;
    gen_rst = 1'b0;

    // Reset state
    check("rst_on", 32'(on), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_clock_op", 32'(clock_op), 32'd0);
    check("rst_ack", 32'(wb.wbs_ack_o), 32'd0);
    wb_read(A_CTRL, 32'h0, "rst_ctrl");
    wb_read(A_STEP, 32'h0, "rst_steps");
    wb_read(A_STAT, 32'h0, "rst_status");
    wb_read(A_RES,  32'h0, "rst_result");
    wb_read(A_CNT,  32'h0, "rst_count");

    // Ten-step run, CLKSEL=0, IRQ enabled
    gen_reset();
    wb_write(A_STEP, 32'd10, 4'hF);
    wb_write(A_CTRL, 32'h101, 4'hF);
    check("run10_on_ack_cycle", 32'(on), 32'd0);
    cycles(1);
    check("run10_on_rise", 32'(on), 32'd1);
    check("run10_clock_op", 32'(clock_op), 32'b000001);
    for (int i = 0; i < 10; i++) begin
      check("run10_on_before_tick", 32'(on), 32'd1);
      tick_pulse();
      if (i == 9) check("run10_on_fall", 32'(on), 32'd0);
      cycles(1);
    end
    cycles(2);
    wb_read(A_CNT,  32'd10, "run10_count");
    wb_read(A_RES,  32'd55, "run10_result");
    wb_read(A_STAT, 32'h2,  "run10_status");
    check("run10_irq", 32'(irq), 32'd1);
    wb_write(A_STAT, 32'h2, 4'h0);
    wb_read(A_STAT, 32'h2, "w1c_no_lane_status");
    wb_write(A_STAT, 32'h2, 4'hF);
    check("w1c_irq_drop", 32'(irq), 32'd0);
    wb_read(A_STAT, 32'h0, "w1c_status");

    // CLKSEL=3, mid-run CLKSEL write, abort after 5 ticks
    gen_reset();
    wb_write(A_STEP, 32'd100, 4'hF);
    wb_write(A_CTRL, 32'h0D, 4'hF);
    cycles(1);
    check("sel3_on", 32'(on), 32'd1);
    check("sel3_clock_op", 32'(clock_op), 32'b001000);
    wb_write(A_CTRL, 32'h04, 4'h1);
    check("midrun_clock_op_held", 32'(clock_op), 32'b001000);
    wb_read(A_CTRL, 32'h04, "midrun_ctrl_readback");
    for (int i = 0; i < 5; i++) begin
      tick_pulse();
      cycles(1);
    end
    wb_write(A_CTRL, 32'h06, 4'h1);
    check("abort_on_ack_cycle", 32'(on), 32'd1);
    cycles(1);
    check("abort_on_fall", 32'(on), 32'd0);
    wb_read(A_STAT, 32'h8,   "abort_status");
    wb_read(A_CNT,  32'd5,   "abort_count");
    wb_read(A_RES,  32'd55,  "abort_result_kept");

    // CLKSEL=7 clamps to 5; run wraps past 2^30 at step 45
    gen_reset();
    wb_write(A_STEP, 32'd60, 4'hF);
    wb_write(A_CTRL, 32'h11D, 4'hF);
    cycles(1);
    check("sel7_clock_op", 32'(clock_op), 32'b100000);
    wb_read(A_CTRL, 32'h114, "sel7_ctrl_clamped");
    for (int i = 0; i < 45; i++) begin
      tick_pulse();
      cycles(1);
    end
    check("ovf_on_fall", 32'(on), 32'd0);
    cycles(2);
    wb_read(A_STAT, 32'h6,         "ovf_status");
    wb_read(A_CNT,  32'd45,        "ovf_count");
    wb_read(A_RES,  32'd61161346,  "ovf_result");
    check("ovf_irq", 32'(irq), 32'd1);

    // START with STEPS=0
    wb_write(A_STAT, 32'hE, 4'hF);
    gen_reset();
    wb_write(A_STEP, 32'd0, 4'hF);
    wb_write(A_CTRL, 32'h101, 4'hF);
    check("zero_on_ack_cycle", 32'(on), 32'd0);
    cycles(1);
    check("zero_on_after", 32'(on), 32'd0);
    wb_read(A_STAT, 32'h2, "zero_status");
    wb_read(A_RES,  32'h0, "zero_result");
    check("zero_irq", 32'(irq), 32'd1);

    // Outside the register window
    wb_xfer(1'b0, BASE + 32'h100, 32'h0, 4'hF, acked);
    check("oow_no_ack", 32'(acked), 32'd0);

    // Asynchronous reset in the middle of a run
    wb_write(A_STEP, 32'd10, 4'hF);
    wb_write(A_CTRL, 32'h109, 4'hF);
    cycles(1);
    check("rstmid_on_before", 32'(on), 32'd1);
    check("rstmid_clock_op_before", 32'(clock_op), 32'b000100);
    tick_pulse();
    cycles(1);
    tick_pulse();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rstmid_on", 32'(on), 32'd0);
    check("rstmid_clock_op", 32'(clock_op), 32'd0);
    check("rstmid_irq", 32'(irq), 32'd0);
    check("rstmid_ack", 32'(wb.wbs_ack_o), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    wb_read(A_STAT, 32'h0, "rstmid_status");
    wb_read(A_CNT,  32'h0, "rstmid_count");
    wb_read(A_STEP, 32'h0, "rstmid_steps");

    cycles(3);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fib_run_ctrl.md
# fib_run_ctrl

Wishbone-mapped run controller for the Fibonacci datapath. Software programs a step count and clock-divider selection, then starts a run. The block drives the generator's `on` switch and one-hot clock select, counts step ticks and stops after exactly N steps or on numeric overflow. It then captures the result and raises an interrupt. It sits between the Wishbone bus and the fibonacci/clkdiv datapath, replacing direct software toggling of the switch.

## Interface
Parameters:
- BASE_ADDR, 32'h3000_0000, word-aligned base of the 5-register window.
- VAL_WIDTH, 30, width of the generator value.
- STEP_WIDTH, 16, width of the step counter and STEPS register.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1  Wishbone strobe, cycle and write-enable.
- wbs_sel_i  in  4  byte lanes, honoured on writes.
- wbs_adr_i, wbs_dat_i  in  32  address and write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- tick  in  1  one-cycle strobe per generator step (selected divided clock edge, already in clk domain).
- value  in  VAL_WIDTH  current generator output.
- on  out  1  generator enable.
- clock_op  out  6  one-hot divider select; all zero selects the undivided clock.
- irq  out  1  done interrupt.

## Operation
Register map (offset from BASE_ADDR):
- 0x00 CTRL
  - bit0 START (write-1 pulse, reads 0)
  - bit1 ABORT (write-1 pulse, reads 0)
  - bits[4:2] CLKSEL (0–5; values 6–7 clamp to 5)
  - bit8 IRQ_EN
- 0x04 STEPS: STEP_WIDTH bits, read/write.
- 0x08 STATUS
  - bit0 BUSY (read-only)
  - bit1 DONE (sticky, write-1-to-clear)
  - bit2 OVF (sticky, write-1-to-clear)
  - bit3 ABORTED (sticky, write-1-to-clear)
- 0x0C RESULT: value captured at end of run, zero-extended.
- 0x10 COUNT: steps completed in the current or last run.

Addresses outside the window get no ack. Reads of unmapped words inside the window return 0.

State machine:
- IDLE: on=0.
  - START with STEPS≠0 → RUN. Entering RUN latches CLKSEL into clock_op, clears COUNT, loads prev=value, and clears DONE/OVF/ABORTED.
  - START with STEPS=0 → sets DONE and stays in IDLE; RESULT=value.
- RUN: on=1, BUSY=1. On each tick, COUNT increments.
  - If COUNT+1 == STEPS → CAPTURE.
  - On the cycle after a tick, if value < prev → set OVF and go to CAPTURE.
  - Otherwise prev=value.
- CAPTURE: on=0; this state lasts one cycle.
  - RESULT is written on the cycle after entry, from value.
  - DONE is set in the same cycle as RESULT is written.
  - The state machine then returns to IDLE.
- ABORT in RUN → IDLE immediately. Sets ABORTED, leaves DONE clear and RESULT unchanged. ABORT in IDLE has no effect.

Other rules:
- Writes to CLKSEL while BUSY update the register, but clock_op holds its latched value until the next START.
- START while BUSY is ignored.
- irq = DONE & IRQ_EN (level); clearing DONE drops irq.
- COUNT saturates at all-ones.

## Timing
- Reset values: wbs_ack_o=0, wbs_dat_o=0, on=0, clock_op=0, irq=0, all registers 0, state IDLE.
- Wishbone ack:
  - wbs_ack_o is asserted one cycle after stb&cyc, for one cycle.
  - It is low in the following cycle even if stb persists, so the minimum transaction is 2 cycles.
  - wbs_dat_o is valid with ack and 0 otherwise.
- Write side effects:
  - START/ABORT act in the cycle ack is asserted.
  - on rises the cycle after that.
  - on falls one cycle after the terminating tick is seen.
- Simultaneous events:
  - Tick in the same cycle as ABORT: ABORT wins; COUNT still increments.
  - W1C of DONE in the same cycle DONE is set: set wins.
- Reset asserted mid-run: on and clock_op drop immediately (asynchronous); no DONE is set.

## Structure
- Shared package `fib_pkg`:
  - register offsets
  - CTRL/STATUS bit indices
  - state enum {IDLE, RUN, CAPTURE}
  - NUM_CLKSEL=6
- Sub-module `fib_wb_regs`: Wishbone decode, ack generation, register file, byte-lane writes and W1C/pulse handling.
- Top module: FSM, counters, capture and overflow compare.

## Test plan
- Reset, then read all registers → all 0; irq=0, on=0.
- STEPS=10, CTRL=0x101 (CLKSEL=0, IRQ_EN), 10 ticks → on high for exactly 10 ticks; COUNT=10; RESULT=55 for a generator reset to 0,1; DONE=1, irq=1. Then STATUS write 0x2 → irq=0.
- CTRL with CLKSEL=3 and START → clock_op=6'b001000. CLKSEL=7 → clock_op=6'b100000. A CLKSEL write mid-run does not change clock_op.
- STEPS=100, ABORT after 5 ticks → on=0 next cycle; ABORTED=1, DONE=0, COUNT=5, RESULT unchanged.
- STEPS=60, with value wrapping past 2^30 at step 45 → OVF=1, DONE=1, COUNT=45, on=0.
- Corner cases:
  - START with STEPS=0 → DONE=1 with no on pulse.
  - Reset asserted mid-run → all outputs 0 asynchronously.
